// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control path: state encodings
// and default sizing constants.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_ERROR  = 3'd7
   } state_t;

   localparam int DEF_MEM_TIMEOUT = 16;
   localparam int DEF_TO_W        = 5;
   localparam int DEF_CNT_W       = 32;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for a memory handshake; flags a timeout when the count
// has reached LIMIT and the handshake is still waiting.
module mem_wait_timer #(
   parameter int LIMIT = 16,
   parameter int TO_W  = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic timeout
);

   localparam logic [TO_W-1:0] LIMIT_V = TO_W'(LIMIT);

   logic [TO_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en && (cnt != LIMIT_V)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign timeout = en && (cnt == LIMIT_V);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: steps each instruction through FETCH/DECODE/EXEC/
// MEM/WB, gates decoder controls into strobes and counts retirements.
module multicycle_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
   parameter int TO_W        = DEF_TO_W,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             dec_reg_write,
   input  logic             dec_mem_write,
   input  logic             dec_mem_to_reg,
   input  logic             dec_branch,
   input  logic             alu_zero,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             rf_we,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired_count,
   output logic             timeout_err
);

   state_t cur, nxt;
   logic   retire;
   logic   waiting;
   logic   wait_clr;
   logic   to_hit;

   // Only the two handshake states accumulate wait cycles; a paused fetch does not.
   assign waiting  = ((cur == S_FETCH) && run && !imem_ready) ||
                     ((cur == S_MEM) && !dmem_ready);
   assign wait_clr = (nxt != cur) || ((cur == S_FETCH) && !run);

   mem_wait_timer #(
      .LIMIT (MEM_TIMEOUT),
      .TO_W  (TO_W)
   ) u_wait (
      .clk     (clk),
      .rst     (rst),
      .clr     (wait_clr),
      .en      (waiting),
      .timeout (to_hit)
   );

   always_comb begin
      nxt      = cur;
      retire   = 1'b0;
      imem_req = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      pc_src   = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      case (cur)
         S_FETCH: begin
            imem_req = run;
            if (run && imem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               nxt      = S_DECODE;
            end else if (to_hit) begin
               nxt = S_ERROR;
            end
         end
         S_DECODE: nxt = S_EXEC;
         S_EXEC: begin
            if (dec_branch) begin
               pc_write = alu_zero;
               pc_src   = 1'b1;
               retire   = 1'b1;
               nxt      = S_FETCH;
            end else if (dec_mem_write || dec_mem_to_reg) begin
               nxt = S_MEM;
            end else if (dec_reg_write) begin
               nxt = S_WB;
            end else begin
               retire = 1'b1;
               nxt    = S_FETCH;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = dec_mem_write;
            // A store takes priority over a simultaneous load flag.
            if (dmem_ready) begin
               if (dec_mem_write) begin
                  retire = 1'b1;
                  nxt    = S_FETCH;
               end else begin
                  nxt = S_WB;
               end
            end else if (to_hit) begin
               nxt = S_ERROR;
            end
         end
         S_WB: begin
            rf_we  = 1'b1;
            retire = 1'b1;
            nxt    = S_FETCH;
         end
         default: nxt = S_ERROR;
      endcase
      if (rst) begin
         imem_req = 1'b0;
         ir_write = 1'b0;
         pc_write = 1'b0;
         pc_src   = 1'b0;
         dmem_req = 1'b0;
         dmem_we  = 1'b0;
         rf_we    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur           <= S_FETCH;
         retired_count <= '0;
         timeout_err   <= 1'b0;
      end else begin
         cur <= nxt;
         if (retire) begin
            retired_count <= retired_count + CNT_W'(1);
         end
         if (to_hit) begin
            timeout_err <= 1'b1;
         end
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle traces built from
// instruction class and random wait counts, compared cycle by cycle.
module tb_multicycle_ctrl;

   localparam int TO = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst, run, regw, memw, m2r, br, zero, ir, dr;
   logic          imem_req, ir_write, pc_write, pc_src, dmem_req, dmem_we, rf_we;
   logic [2:0]    state;
   logic [CW-1:0] retired_count;
   logic          timeout_err;

   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_TIMEOUT(TO), .TO_W(5), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .run(run),
      .dec_reg_write(regw), .dec_mem_write(memw), .dec_mem_to_reg(m2r),
      .dec_branch(br), .alu_zero(zero), .imem_ready(ir), .dmem_ready(dr),
      .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
      .pc_src(pc_src), .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we),
      .state(state), .retired_count(retired_count), .timeout_err(timeout_err)
   );

   typedef struct {
      logic       i;
      logic       d;
      logic [2:0] st;
      logic [6:0] o;
      logic       err;
   } cyc_t;

   cyc_t        q[$];
   int          total = 0;
   int          bad   = 0;
   int unsigned model_cnt = 0;

   function automatic logic [6:0] outs_now();
      return {imem_req, ir_write, pc_write, pc_src, dmem_req, dmem_we, rf_we};
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic i, input logic d, input logic [2:0] st,
                       input logic [6:0] o, input logic err);
      cyc_t c;
      c.i = i; c.d = d; c.st = st; c.o = o; c.err = err;
      q.push_back(c);
   endtask

   // kinds: 0 alu, 1 beq, 2 store, 3 load, 4 nop, 5 store+load flags
   task automatic build_instr(input int kind, input int wi, input int wd, input logic z);
      logic b, s, l, w;
      logic [6:0] mo;
      b = (kind == 1);
      s = (kind == 2) || (kind == 5);
      l = (kind == 3) || (kind == 5);
      w = (kind == 0) || (kind == 3) || ((kind == 1) && rnd());
      regw = w; memw = s; m2r = l; br = b; zero = z;
      repeat (wi) push(1'b0, rnd(), 3'd0, 7'b1000000, 1'b0);
      push(1'b1, rnd(), 3'd0, 7'b1110000, 1'b0);
      push(rnd(), rnd(), 3'd1, 7'b0, 1'b0);
      if (b) begin
         push(rnd(), rnd(), 3'd2, {2'b00, z, 1'b1, 3'b000}, 1'b0);
         model_cnt++;
      end else if (s || l) begin
         mo = {4'b0000, 1'b1, s, 1'b0};
         push(rnd(), rnd(), 3'd2, 7'b0, 1'b0);
         repeat (wd) push(rnd(), 1'b0, 3'd3, mo, 1'b0);
         push(rnd(), 1'b1, 3'd3, mo, 1'b0);
         if (!s) push(rnd(), rnd(), 3'd4, 7'b0000001, 1'b0);
         model_cnt++;
      end else begin
         push(rnd(), rnd(), 3'd2, 7'b0, 1'b0);
         if (w) push(rnd(), rnd(), 3'd4, 7'b0000001, 1'b0);
         model_cnt++;
      end
   endtask

   task automatic play(input string tag);
      cyc_t c;
      logic [CW-1:0] exp_cnt;
      while (q.size() > 0) begin
         c = q.pop_front();
         ir = c.i; dr = c.d;
         #2;
         total++;
         if ({state, outs_now(), timeout_err} !== {c.st, c.o, c.err}) begin
            bad++;
            $display("FAIL %s t=%0t got st=%0d out=%b err=%b want st=%0d out=%b err=%b",
                     tag, $time, state, outs_now(), timeout_err, c.st, c.o, c.err);
         end
         @(posedge clk); #1;
      end
      exp_cnt = CW'(model_cnt);
      total++;
      if (retired_count !== exp_cnt) begin
         bad++;
         $display("FAIL %s_count got=%0d want=%0d", tag, retired_count, exp_cnt);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; run = 1'b1; ir = 1'b1; dr = 1'b1;
      regw = 1'b1; memw = 1'b0; m2r = 1'b0; br = 1'b0; zero = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({state, outs_now(), retired_count, timeout_err} !== {3'd0, 7'b0, CW'(0), 1'b0}) begin
         bad++;
         $display("FAIL reset got st=%0d out=%b cnt=%0d err=%b want all zero",
                  state, outs_now(), retired_count, timeout_err);
      end
      rst = 1'b0; ir = 1'b0; dr = 1'b0;
      #1;
      total++;
      if (outs_now() !== 7'b1000000) begin
         bad++;
         $display("FAIL reset_release got out=%b want=1000000", outs_now());
      end
      run = 1'b0;
      @(posedge clk); #1;
      run = 1'b1;
      model_cnt = 0;
   endtask

   task automatic test_alu();
      build_instr(0, 0, 0, 1'b0); play("add");
      build_instr(4, 0, 0, 1'b0); play("nop");
   endtask

   task automatic test_branch();
      build_instr(1, 0, 0, 1'b1); play("beq_taken");
      build_instr(1, 0, 0, 1'b0); play("beq_not_taken");
   endtask

   task automatic test_load_store();
      build_instr(3, 0, 3, 1'b0); play("load_wait3");
      build_instr(2, 0, 0, 1'b0); play("store");
      build_instr(5, 0, TO, 1'b0); play("store_wins_at_limit");
      build_instr(3, TO, TO, 1'b0); play("fetch_and_load_at_limit");
   endtask

   task automatic test_run_gate();
      logic [6:0] want;
      for (int k = 0; k < 11; k++) begin
         run = (k >= 6 && k < 9);
         ir  = (k < 6);
         want = run ? 7'b1000000 : 7'b0;
         #2;
         total++;
         if ({state, outs_now(), timeout_err} !== {3'd0, want, 1'b0}) begin
            bad++;
            $display("FAIL run_gate k=%0d got st=%0d out=%b err=%b want st=0 out=%b err=0",
                     k, state, outs_now(), timeout_err, want);
         end
         @(posedge clk); #1;
      end
      run = 1'b1;
      build_instr(0, TO, 0, 1'b0); play("run_resume");
   endtask

   task automatic test_timeout();
      logic [CW-1:0] exp_cnt;
      regw = 1'b0; memw = 1'b1; m2r = 1'b0; br = 1'b0; zero = 1'b0;
      push(1'b1, rnd(), 3'd0, 7'b1110000, 1'b0);
      push(rnd(), rnd(), 3'd1, 7'b0, 1'b0);
      push(rnd(), rnd(), 3'd2, 7'b0, 1'b0);
      repeat (TO + 1) push(rnd(), 1'b0, 3'd3, 7'b0000110, 1'b0);
      repeat (6) push(rnd(), rnd(), 3'd7, 7'b0, 1'b1);
      play("store_timeout");
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_cnt = 0;
      exp_cnt = '0;
      total++;
      if ({state, retired_count, timeout_err} !== {3'd0, exp_cnt, 1'b0}) begin
         bad++;
         $display("FAIL error_reset got st=%0d cnt=%0d err=%b want st=0 cnt=0 err=0",
                  state, retired_count, timeout_err);
      end
      build_instr(0, 0, 0, 1'b0); play("after_error");
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         build_instr(int'($urandom_range(0, 5)), int'($urandom_range(0, TO)),
                     int'($urandom_range(0, TO)), rnd());
         play("random");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_alu();
      test_branch();
      test_load_store();
      test_run_gate();
      test_timeout();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the single-issue CPU datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- It consumes the per-instruction control outputs of the instruction decoder. It gates them into one-cycle write enables for the PC, IR, register file and data memory.
- It runs ready/request handshakes with the instruction and data memories, counts retired instructions, and flags memory timeouts.

Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles on a memory handshake before an error is raised (must be 1 to 2^TO_W-1).
- TO_W, 5: width of the wait counter.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  when 0, the FSM may not leave FETCH or start a fetch.
- dec_reg_write  in  1  decoder: instruction writes the register file.
- dec_mem_write  in  1  decoder: instruction is a store.
- dec_mem_to_reg  in  1  decoder: instruction is a load.
- dec_branch  in  1  decoder: instruction is beq.
- alu_zero  in  1  ALU zero flag, valid in EXEC.
- imem_ready  in  1  instruction memory has data or has completed.
- dmem_ready  in  1  data memory has completed the access.
- imem_req  out  1  instruction read request.
- ir_write  out  1  latch the instruction register.
- pc_write  out  1  update the PC.
- pc_src  out  1  0 selects PC+4; 1 selects the branch target.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write strobe.
- rf_we  out  1  register-file write enable.
- state  out  3  current state encoding, for debug.
- retired_count  out  CNT_W  number of retired instructions.
- timeout_err  out  1  sticky memory-timeout flag.

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=7.
- Reset: state=FETCH; wait counter=0; retired_count=0; timeout_err=0. Reset overrides everything, including reset asserted mid-instruction or in ERROR.
- Outputs are combinational from the state plus the ready inputs. Every output is 0 unless a rule below drives it, so all outputs are 0 during reset and in ERROR.
- FETCH:
  - imem_req=run.
  - When run=1 and imem_ready=1: ir_write=1, pc_write=1, pc_src=0, and the next state is DECODE.
  - When run=0, imem_ready is ignored and the FSM stays in FETCH.
- DECODE: one cycle, no outputs asserted, then EXEC.
- EXEC: one cycle; the next step is chosen by the first matching rule:
  1. dec_branch=1: pc_write=alu_zero, pc_src=1, retire, go to FETCH.
  2. dec_mem_write=1 or dec_mem_to_reg=1: go to MEM.
  3. dec_reg_write=1: go to WB.
  4. Otherwise: retire (treated as a nop), go to FETCH.
- MEM:
  - dmem_req=1 and dmem_we=dec_mem_write, held until dmem_ready.
  - On dmem_ready with a store: retire, go to FETCH.
  - On dmem_ready with a load: go to WB.
  - If dec_mem_write and dec_mem_to_reg are both set, the store wins and no WB follows.
- WB: rf_we=1 for exactly one cycle, retire, go to FETCH.
- Retire: retired_count increments by 1 on the same edge the FSM leaves for FETCH. It wraps modulo 2^CNT_W with no flag.
- Latency with zero-wait memory: R-type 4 cycles, branch 3, store 4, load 5.
- Wait counter:
  - Counts cycles spent in FETCH (only while run=1) or MEM with ready low.
  - Clears on any state change, and when run=0.
  - When the counter equals MEM_TIMEOUT and ready is still low: next state is ERROR and timeout_err is set to 1.
  - A ready arriving on the same cycle the counter reaches the limit wins; the transition proceeds normally.
- ERROR: absorbing until rst; all strobes are 0 and retired_count is frozen.
- Ready inputs seen outside their request state are ignored.
- Decoder inputs must be stable from DECODE through WB; the block does not latch them.

Decomposition:
- A shared package cpu_ctrl_pkg holds:
  - the state encodings (S_FETCH..S_ERROR, 3 bits);
  - default parameter constants.
- Sub-module mem_wait_timer (counter with clear, enable and limit compare, producing a timeout pulse) is factored out. Both handshake states use it.
- The rest stays in one FSM module with a registered state and combinational next-state/output logic.

Test Plan:
1. Reset behaviour: rst=1 for 2 cycles with run=1 -> all outputs 0, state=0, retired_count=0. Release rst -> imem_req=1 on the next cycle.
2. add, zero-wait memory (dec_reg_write=1): FETCH, DECODE, EXEC, WB -> rf_we high exactly 1 cycle in WB, retired_count=1 after 4 cycles.
3. beq: with alu_zero=1 -> pc_write=1 and pc_src=1 in EXEC. With alu_zero=0 -> pc_write=0. Each branch takes 3 cycles and increments retired_count.
4. Load with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0, then one rf_we pulse; total 8 cycles.
5. Store with MEM_TIMEOUT=4 and dmem_ready never asserted -> state=7 and timeout_err=1 after the limit; all strobes stay 0 until rst; rst returns state to 0.
6. run=0 during FETCH with imem_ready=1 -> no ir_write, imem_req=0, no timeout raised. Set run=1 -> fetch completes the next cycle. Also preload retired_count at 2^CNT_W-1 (or retire at CNT_W=4 for 16 instructions) -> counter wraps to 0.
